// File: rtl/fsm_hamster_game.sv
// Whack-a-mole game controller: hold, timed play, LFSR mole placement, pop timeout, hit/miss scoring.
// Optional lives rule enabled by defining HAMSTER_LIVES_EN.
module fsm_hamster_game #(
  parameter int         N_HOLES    = 10,
  parameter int         SCORE_W    = 8,
  parameter int         GAME_TICKS = 210,
  parameter int         POP_TICKS  = 15,
  parameter int         MAX_MISS   = 5,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tick,
  input  logic                               pb_start,
  input  logic                               pb_clear,
  input  logic [N_HOLES-1:0]                 hamster,
  output logic [2:0]                         state,
  output logic [N_HOLES-1:0]                 mole,
  output logic [SCORE_W-1:0]                 score,
  output logic [3:0]                         misses,
  output logic [$clog2(GAME_TICKS+1)-1:0]    time_left,
  output logic                               game_over
);

  localparam int TW = $clog2(GAME_TICKS + 1);
  localparam int PW = $clog2(POP_TICKS + 1);
  localparam int HW = $clog2(N_HOLES);

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_POP  = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_MISS = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  localparam logic [N_HOLES-1:0] ONE_HOT0 = N_HOLES'(1);

`ifdef HAMSTER_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic [2:0]         state_q, state_d;
  logic [7:0]         lfsr_q;
  logic [HW-1:0]      pos_q, pos_d, cand_pos, new_pos;
  logic [PW-1:0]      pop_q, pop_d;
  logic [TW-1:0]      time_d;
  logic [SCORE_W-1:0] score_d;
  logic [3:0]         misses_d;
  logic [N_HOLES-1:0] mole_d;
  logic               game_over_d;
  logic               hit, expire, pop_out, lives_out, all_clear, in_play, load_mole;

  assign state = state_q;

  // A repeated position is bumped to the next hole so consecutive moles always differ.
  always_comb begin
    cand_pos  = HW'(lfsr_q % 8'(N_HOLES));
    new_pos   = (cand_pos != pos_q) ? cand_pos :
                (cand_pos == HW'(N_HOLES - 1)) ? '0 : cand_pos + HW'(1);
    hit       = hamster[pos_q];
    all_clear = (hamster == '0);
    in_play   = (state_q == S_POP) || (state_q == S_HIT) || (state_q == S_MISS);
    expire    = in_play && tick && (time_left <= TW'(1));
    pop_out   = tick && (pop_q == PW'(1));
    lives_out = LIVES_EN && (misses >= 4'(MAX_MISS));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HOLD;
    else     state_q <= state_d;
  end

  // Timer expiry outranks hit and miss in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: if (pb_start) state_d = S_POP;
      S_POP: begin
        if (expire)       state_d = S_STOP;
        else if (hit)     state_d = S_HIT;
        else if (pop_out) state_d = S_MISS;
      end
      S_HIT: begin
        if (expire)         state_d = S_STOP;
        else if (all_clear) state_d = S_POP;
      end
      S_MISS: begin
        if (expire || lives_out) state_d = S_STOP;
        else                     state_d = S_POP;
      end
      S_STOP: if (pb_clear) state_d = S_HOLD;
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    load_mole = (state_d == S_POP) && (state_q != S_POP);
    pos_d     = load_mole ? new_pos : pos_q;
    mole_d    = (state_d == S_POP) ? (ONE_HOT0 << pos_d) : '0;

    pop_d = pop_q;
    if (load_mole)                                      pop_d = PW'(POP_TICKS);
    else if (state_q == S_POP && tick && pop_q != '0)   pop_d = pop_q - PW'(1);

    time_d = time_left;
    if ((state_q == S_HOLD && pb_start) || (state_q == S_STOP && pb_clear))
      time_d = TW'(GAME_TICKS);
    else if (in_play && tick && time_left != '0)
      time_d = time_left - TW'(1);

    score_d  = score;
    misses_d = misses;
    if (state_q == S_HOLD && (pb_start || pb_clear)) begin
      score_d  = '0;
      misses_d = '0;
    end else if (state_q == S_POP && state_d == S_HIT) begin
      if (score != '1) score_d = score + SCORE_W'(1);
    end else if (state_q == S_POP && state_d == S_MISS) begin
      if (misses != 4'hF) misses_d = misses + 4'd1;
    end

    game_over_d = (state_d == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= LFSR_SEED;
      pos_q     <= '0;
      pop_q     <= '0;
      mole      <= '0;
      score     <= '0;
      misses    <= '0;
      time_left <= TW'(GAME_TICKS);
      game_over <= 1'b0;
    end else begin
      lfsr_q    <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      pos_q     <= pos_d;
      pop_q     <= pop_d;
      mole      <= mole_d;
      score     <= score_d;
      misses    <= misses_d;
      time_left <= time_d;
      game_over <= game_over_d;
    end
  end

endmodule

// File: tb/tb_fsm_hamster_game.sv
// Directed bench for fsm_hamster_game: a default-size game and a 4-hole / 2-bit-score game.
module tb_fsm_hamster_game;

  localparam int         GT   = 210;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst_a = 1'b1, tick_a = 1'b0, start_a = 1'b0, clear_a = 1'b0;
  logic [9:0] ham_a = '0;
  logic [2:0] state_a;
  logic [9:0] mole_a;
  logic [7:0] score_a;
  logic [3:0] misses_a;
  logic [7:0] time_a;
  logic       go_a;

  // small instance
  logic       rst_b = 1'b1, tick_b = 1'b0, start_b = 1'b0, clear_b = 1'b0;
  logic [3:0] ham_b = '0;
  logic [2:0] state_b;
  logic [3:0] mole_b;
  logic [1:0] score_b;
  logic [3:0] misses_b;
  logic [7:0] time_b;
  logic       go_b;

  fsm_hamster_game u_dut_a (
    .clk(clk), .rst(rst_a), .tick(tick_a), .pb_start(start_a), .pb_clear(clear_a),
    .hamster(ham_a), .state(state_a), .mole(mole_a), .score(score_a),
    .misses(misses_a), .time_left(time_a), .game_over(go_a)
  );

  fsm_hamster_game #(.N_HOLES(4), .SCORE_W(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .tick(tick_b), .pb_start(start_b), .pb_clear(clear_b),
    .hamster(ham_b), .state(state_b), .mole(mole_b), .score(score_b),
    .misses(misses_b), .time_left(time_b), .game_over(go_b)
  );

  // reference LFSRs; *_prev holds the value the DUT saw in the cycle just sampled
  logic [7:0] ma_l, ma_prev, mb_l, mb_prev;

  function automatic logic [7:0] lnext(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int pick(input logic [7:0] l, input int prev, input int n);
    int p;
    p = int'(l) % n;
    if (p == prev) p = (p + 1) % n;
    return p;
  endfunction

  function automatic logic [31:0] oh(input int p);
    return 32'd1 << p;
  endfunction

  always @(posedge clk) begin
    ma_l    <= rst_a ? SEED : lnext(ma_l);
    ma_prev <= ma_l;
    mb_l    <= rst_b ? SEED : lnext(mb_l);
    mb_prev <= mb_l;
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: got %0h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a_pulse();
    tick_a = 1'b1; step();
    tick_a = 1'b0; step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int pos_a, pos_b, exp_score, exp_time, since, exp_b;

  initial begin
    // reset state
    step(); step(); step();
    push(0);  chk("rst_state", 32'(state_a));
    push(0);  chk("rst_mole", 32'(mole_a));
    push(0);  chk("rst_score", 32'(score_a));
    push(0);  chk("rst_misses", 32'(misses_a));
    push(GT); chk("rst_time", 32'(time_a));
    push(0);  chk("rst_go", 32'(go_a));
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // start: first mole is one-hot
    start_a = 1'b1; step(); start_a = 1'b0;
    push(1);  chk("start_state", 32'(state_a));
    push(1);  chk("start_onehot", 32'($countones(mole_a)));
    push(GT); chk("start_time", 32'(time_a));
    push(0);  chk("start_score", 32'(score_a));
    pos_a = 0;
    for (int i = 0; i < 10; i++) if (mole_a[i]) pos_a = i;

    // hit, hold, release
    ham_a = 10'(oh(pos_a)); step();
    push(2); chk("hit_state", 32'(state_a));
    push(1); chk("hit_score", 32'(score_a));
    push(0); chk("hit_mole", 32'(mole_a));
    step();
    push(2); chk("hit_hold", 32'(state_a));
    ham_a = '0; step();
    pos_a = pick(ma_prev, pos_a, 10);
    push(1);         chk("release_state", 32'(state_a));
    push(oh(pos_a)); chk("release_mole", 32'(mole_a));

    // 14 ticks with only non-matching sensors, then timeout on the 15th
    ham_a = ~10'(oh(pos_a));
    for (int i = 0; i < 14; i++) begin
      tick_a_pulse();
      push(1); chk("nomatch_pop", 32'(state_a));
    end
    push(GT - 14); chk("nomatch_time", 32'(time_a));
    push(1);       chk("nomatch_score", 32'(score_a));
    tick_a = 1'b1; ham_a = '0; step(); tick_a = 1'b0;
    push(3);       chk("miss_state", 32'(state_a));
    push(1);       chk("miss_count", 32'(misses_a));
    push(0);       chk("miss_mole", 32'(mole_a));
    push(GT - 15); chk("miss_time", 32'(time_a));
    step();
    pos_a = pick(ma_prev, pos_a, 10);
    push(1);         chk("after_miss_state", 32'(state_a));
    push(oh(pos_a)); chk("after_miss_mole", 32'(mole_a));
    exp_score = 1;
    exp_time  = GT - 15;

    // four more timeouts: five misses in total
    for (int m = 2; m <= 5; m++) begin
      for (int i = 0; i < 14; i++) tick_a_pulse();
      tick_a = 1'b1; step(); tick_a = 1'b0;
      exp_time -= 15;
      push(3); chk("lives_miss_state", 32'(state_a));
      push(m); chk("lives_miss_count", 32'(misses_a));
      step();
`ifdef HAMSTER_LIVES_EN
      if (m == 5) begin
        push(4);        chk("lives_stop_state", 32'(state_a));
        push(1);        chk("lives_stop_go", 32'(go_a));
        push(exp_time); chk("lives_stop_time", 32'(time_a));
        push(1);        chk("lives_time_left", 32'(time_a > 0));
      end else begin
        pos_a = pick(ma_prev, pos_a, 10);
        push(1);         chk("lives_pop_state", 32'(state_a));
        push(oh(pos_a)); chk("lives_pop_mole", 32'(mole_a));
      end
`else
      pos_a = pick(ma_prev, pos_a, 10);
      push(1);         chk("lives_pop_state", 32'(state_a));
      push(oh(pos_a)); chk("lives_pop_mole", 32'(mole_a));
`endif
    end
`ifdef HAMSTER_LIVES_EN
    clear_a = 1'b1; step(); clear_a = 1'b0;
    push(0);  chk("lives_clear_state", 32'(state_a));
    push(GT); chk("lives_clear_time", 32'(time_a));
    start_a = 1'b1; step(); start_a = 1'b0;
    pos_a = pick(ma_prev, pos_a, 10);
    push(1);         chk("restart_state", 32'(state_a));
    push(oh(pos_a)); chk("restart_mole", 32'(mole_a));
    push(0);         chk("restart_score", 32'(score_a));
    push(0);         chk("restart_misses", 32'(misses_a));
    exp_score = 0;
    exp_time  = GT;
`else
    push(5); chk("nolives_misses", 32'(misses_a));
`endif

    // play to expiry, hitting every 10 ticks
    since = 0;
    while (exp_time > 1) begin
      if (since == 10) begin
        ham_a = 10'(oh(pos_a)); step();
        exp_score++;
        push(2);         chk("play_hit_state", 32'(state_a));
        push(exp_score); chk("play_hit_score", 32'(score_a));
        ham_a = '0; step();
        pos_a = pick(ma_prev, pos_a, 10);
        push(oh(pos_a)); chk("play_mole", 32'(mole_a));
        since = 0;
      end
      tick_a_pulse();
      exp_time--;
      since++;
    end
    push(1); chk("play_time1", 32'(time_a));

    // final tick coincides with a hit: expiry wins, hit not counted
    tick_a = 1'b1; ham_a = 10'(oh(pos_a)); step();
    tick_a = 1'b0; ham_a = '0;
    push(4);         chk("expire_state", 32'(state_a));
    push(1);         chk("expire_go", 32'(go_a));
    push(exp_score); chk("expire_score", 32'(score_a));
    push(0);         chk("expire_time", 32'(time_a));
    push(0);         chk("expire_mole", 32'(mole_a));
    start_a = 1'b1; step(); start_a = 1'b0;
    push(4); chk("stop_ignores_start", 32'(state_a));
    clear_a = 1'b1; step(); clear_a = 1'b0;
    push(0);  chk("clear_state", 32'(state_a));
    push(GT); chk("clear_time", 32'(time_a));
    push(0);  chk("clear_go", 32'(go_a));

    // small game: score saturates at 3, then reset mid-POP
    start_b = 1'b1; step(); start_b = 1'b0;
    push(1); chk("b_start_state", 32'(state_b));
    push(1); chk("b_start_onehot", 32'($countones(mole_b)));
    pos_b = 0;
    for (int i = 0; i < 4; i++) if (mole_b[i]) pos_b = i;
    exp_b = 0;
    for (int h = 0; h < 4; h++) begin
      ham_b = 4'(oh(pos_b)); step();
      if (exp_b < 3) exp_b++;
      push(2);     chk("b_hit_state", 32'(state_b));
      push(exp_b); chk("b_hit_score", 32'(score_b));
      ham_b = '0; step();
      pos_b = pick(mb_prev, pos_b, 4);
      push(1);         chk("b_pop_state", 32'(state_b));
      push(oh(pos_b)); chk("b_pop_mole", 32'(mole_b));
    end
    rst_b = 1'b1; step(); rst_b = 1'b0;
    push(0); chk("b_rst_state", 32'(state_b));
    push(0); chk("b_rst_score", 32'(score_b));
    push(0); chk("b_rst_mole", 32'(mole_b));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
